// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer between instruction memory and IF_ID.
// Owns the fetch PC, fetches one instruction per cycle into a circular queue
// while space remains, and presents the oldest {pc, instr} pair downstream.
// A redirect (taken branch) flushes every prefetched entry and reloads the PC.
//
// Handshake: the head entry is offered whenever out_valid is high; it is
// consumed on a rising edge where out_valid=1 and stall=0 (stall is the
// inverse of ready). While stalled, out_valid/out_pc/out_instr hold stable.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [63:0]                imem_addr,
  input  logic [31:0]                imem_instr,
  input  logic                       redirect,
  input  logic [63:0]                redirect_addr,
  input  logic                       stall,
  output logic                       out_valid,
  output logic [31:0]                out_instr,
  output logic [63:0]                out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [63:0]   fetch_pc;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [63:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic full;
  logic pop;
  logic push;

  // Queue control: pop when the head is taken, push when a slot is free
  // (or being freed by this cycle's pop) and no redirect is flushing.
  always_comb begin
    full = (count == CW'(DEPTH));
    pop  = out_valid & ~stall;
    push = ~redirect & (~full | pop);
  end

  // Fetch PC, pointers and occupancy; reset beats redirect, redirect beats all.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_addr;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        tail     <= tail + PW'(1);
        fetch_pc <= fetch_pc + 64'd4;
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage: written at the tail on every push; contents need no reset
  // because count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem[tail]    <= fetch_pc;
      instr_mem[tail] <= imem_instr;
    end
  end

  // Outputs: head entry when valid, zeros when the queue is empty.
  always_comb begin
    imem_addr = fetch_pc;
    out_valid = (count != '0);
    out_pc    = '0;
    out_instr = '0;
    if (out_valid) begin
      out_pc    = pc_mem[head];
      out_instr = instr_mem[head];
    end
  end

endmodule
